// File: rtl/flags_ctrl_pkg.sv
// flags_ctrl_pkg: NZCV bit positions and ARM condition-code encodings shared by the flag logic
// and the branch unit.
package flags_ctrl_pkg;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_AL = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;
endpackage

// File: rtl/flags_ctrl_cond_eval.sv
// flags_cond_eval: combinational ARM condition-code test of cond_code against {N,Z,C,V}.
module flags_cond_eval
    import flags_ctrl_pkg::*;
(
    input  logic [3:0] cond_code,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];
    always_comb begin
        pass = 1'b0;
        case (cond_code)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = n == v;
            CC_LT: pass = n != v;
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/flags_ctrl.sv
// flags_ctrl: NZCV flag register with restore/write/ALU arbitration, LIFO save stack and
// condition evaluation. Define FLAGS_COND_REG_EN to register cond_pass by one cycle.
module flags_ctrl
    import flags_ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    input  logic [3:0] alu_flags,
    output logic       alu_ready,
    input  logic       wr_valid,
    input  logic [3:0] wr_flags,
    output logic       wr_ready,
    input  logic       save_req,
    input  logic       restore_req,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err,
    input  logic [3:0] cond_code,
    output logic       cond_pass,
    output logic [3:0] flags
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;

    logic [3:0]    stack [STACK_DEPTH];
    logic [PW-1:0] ptr, ptr_dec;
    logic          push_ok, pop_ok, err, pass_c;

    assign stack_full  = ptr == PW'(STACK_DEPTH);
    assign stack_empty = ptr == '0;
    assign ptr_dec     = ptr - PW'(1);
    assign push_ok     = save_req && !restore_req && !stack_full;
    assign pop_ok      = restore_req && !save_req && !stack_empty;
    assign err         = (save_req && restore_req) || (save_req && stack_full) ||
                         (restore_req && stack_empty);
    assign wr_ready    = !reset && !pop_ok;
    assign alu_ready   = !reset && !pop_ok && !wr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= '0;
            ptr       <= '0;
            stack_err <= 1'b0;
        end else begin
            stack_err <= err;
            if (pop_ok) begin
                flags <= stack[ptr_dec[AW-1:0]];
                ptr   <= ptr_dec;
            end else begin
                flags <= wr_valid ? wr_flags : alu_valid ? alu_flags : flags;
                if (push_ok)
                    ptr <= ptr + PW'(1);
            end
        end
    end

    // Push captures the pre-update flags so a same-cycle ALU result is not lost.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            stack[ptr[AW-1:0]] <= flags;
    end

    flags_cond_eval u_eval (
        .cond_code(cond_code),
        .flags    (flags),
        .pass     (pass_c)
    );

`ifdef FLAGS_COND_REG_EN
    always_ff @(posedge clk) begin
        cond_pass <= reset ? 1'b0 : pass_c;
    end
`else
    assign cond_pass = pass_c;
`endif
endmodule
